// File: rtl/ram_arbiter_if.sv
// Requester port of the RAM arbiter: request/write fields in, ack and read return out.
// master = requesting block, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// Latency: req -> ack/ram_en 1 cycle; read grant -> rvalid RD_LAT+1 cycles.
// Backpressure: a requester holds req until ack; a losing requester simply waits.
module ram_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    ram_arbiter_if.slave      m0,
    ram_arbiter_if.slave      m1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef struct packed {
        logic is_read;
        logic id;
    } rd_tag_t;

    logic    elig0, elig1;
    logic    win0, win1;
    logic    last_grant;
    rd_tag_t rd_pipe [RD_LAT];
    rd_tag_t rd_out;

    // A master in its ack cycle is still holding the old request, so it is excluded.
    always_comb begin
        elig0 = m0.req & ~m0.ack;
        elig1 = m1.req & ~m1.ack;
        win0  = elig0 & (~elig1 | last_grant);
        win1  = elig1 & ~win0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m0.ack     <= 1'b0;
            m1.ack     <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            last_grant <= 1'b1;
        end else begin
            m0.ack <= win0;
            m1.ack <= win1;
            ram_en <= win0 | win1;
            ram_we <= (win0 & m0.we) | (win1 & m1.we);
            if (win0) begin
                ram_addr   <= m0.addr;
                ram_wdata  <= m0.wdata;
                last_grant <= 1'b0;
            end else if (win1) begin
                ram_addr   <= m1.addr;
                ram_wdata  <= m1.wdata;
                last_grant <= 1'b1;
            end
        end
    end

    // last_grant doubles as the owner of the access currently on the RAM port.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= {ram_en & ~ram_we, last_grant};
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_out = rd_pipe[RD_LAT-1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m0.rvalid <= 1'b0;
            m1.rvalid <= 1'b0;
            m0.rdata  <= '0;
            m1.rdata  <= '0;
        end else begin
            m0.rvalid <= rd_out.is_read & ~rd_out.id;
            m1.rvalid <= rd_out.is_read & rd_out.id;
            if (rd_out.is_read && !rd_out.id) begin
                m0.rdata <= ram_rdata;
            end
            if (rd_out.is_read && rd_out.id) begin
                m1.rdata <= ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share one stimulus stream,
// each with its own behavioural RAM, compared against a transaction-level reference model.
module tb_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]    m_req = '0;
    logic [1:0]    m_we  = '0;
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    assign a0.req = m_req[0];  assign a0.we = m_we[0];  assign a0.addr = m_addr[0];  assign a0.wdata = m_wdata[0];
    assign a1.req = m_req[1];  assign a1.we = m_we[1];  assign a1.addr = m_addr[1];  assign a1.wdata = m_wdata[1];
    assign b0.req = m_req[0];  assign b0.we = m_we[0];  assign b0.addr = m_addr[0];  assign b0.wdata = m_wdata[0];
    assign b1.req = m_req[1];  assign b1.we = m_we[1];  assign b1.addr = m_addr[1];  assign b1.wdata = m_wdata[1];

    logic          a_en, a_we, b_en, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m0(a0), .m1(a1),
        .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wdata), .ram_rdata(a_rdata));

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m0(b0), .m1(b1),
        .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata), .ram_rdata(b_rdata));

    // Behavioural RAMs: one- and two-cycle read pipelines.
    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];
    logic [DW-1:0] rb1;
    always @(posedge sys_clk) begin
        if (a_en && a_we) mem_a[a_addr] <= a_wdata;
        if (a_en && !a_we) a_rdata <= mem_a[a_addr];
        if (b_en && b_we) mem_b[b_addr] <= b_wdata;
        if (b_en && !b_we) rb1 <= mem_b[b_addr];
        b_rdata <= rb1;
    end

    // Reference model: who gets served each cycle and what each read must return.
    typedef struct { int due; int id; logic [DW-1:0] data; } rd_ev_t;
    rd_ev_t        qa[$], qb[$];
    logic [DW-1:0] shadow [32];
    logic [1:0]    e_ack, e_rv_a, e_rv_b;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rd_a [2];
    logic [DW-1:0] e_rd_b [2];
    int            last_g, cyc, win;
    logic          el0, el1;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            e_ack = '0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            e_rv_a = '0; e_rv_b = '0; last_g = 1;
            for (int i = 0; i < 2; i++) begin e_rd_a[i] = '0; e_rd_b[i] = '0; end
            qa.delete(); qb.delete();
        end else begin
            cyc++;
            el0 = m_req[0] && !e_ack[0];
            el1 = m_req[1] && !e_ack[1];
            if (el0 && el1)  win = (last_g == 1) ? 0 : 1;
            else if (el0)    win = 0;
            else if (el1)    win = 1;
            else             win = -1;
            e_ack = '0; e_en = (win >= 0); e_we = 1'b0;
            if (win >= 0) begin
                last_g = win; e_ack[win] = 1'b1;
                e_we = m_we[win]; e_addr = m_addr[win]; e_wdata = m_wdata[win];
                if (m_we[win]) shadow[m_addr[win]] = m_wdata[win];
                else begin
                    qa.push_back('{due: cyc + 2, id: win, data: shadow[m_addr[win]]});
                    qb.push_back('{due: cyc + 3, id: win, data: shadow[m_addr[win]]});
                end
            end
            e_rv_a = '0; e_rv_b = '0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                e_rv_a[qa[0].id] = 1'b1; e_rd_a[qa[0].id] = qa[0].data; void'(qa.pop_front());
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e_rv_b[qb[0].id] = 1'b1; e_rd_b[qb[0].id] = qb[0].data; void'(qb.pop_front());
            end
        end
    end

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int gap; } op_t;
    op_t ops0[$], ops1[$];

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if ({a0.ack, a1.ack, a0.rvalid, a1.rvalid, a0.rdata, a1.rdata, a_en, a_we, a_addr, a_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_a: got ack=%b%b en=%b we=%b addr=%0d wdata=%h want all 0", a1.ack, a0.ack, a_en, a_we, a_addr, a_wdata);
        end
        n_tests++;
        if ({b0.ack, b1.ack, b0.rvalid, b1.rvalid, b0.rdata, b1.rdata, b_en, b_we, b_addr, b_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_b: got ack=%b%b en=%b we=%b addr=%0d wdata=%h want all 0", b1.ack, b0.ack, b_en, b_we, b_addr, b_wdata);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge sys_clk);
        m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 5'd5; m_wdata[0] = 8'hA5;
        @(negedge sys_clk);
        n_tests++;
        if ({a0.ack, a_en, a_we, a_addr, a_wdata} !== {3'b111, 5'd5, 8'hA5}) begin
            n_fail++; $display("FAIL single_write: got ack=%b en=%b we=%b addr=%0d wdata=%h want 1 1 1 5 a5", a0.ack, a_en, a_we, a_addr, a_wdata);
        end
        n_tests++;
        if ({a1.ack, a1.rvalid, a0.rvalid} !== 3'b000) begin
            n_fail++; $display("FAIL single_write_quiet: got m1_ack=%b m1_rvalid=%b m0_rvalid=%b want 0", a1.ack, a1.rvalid, a0.rvalid);
        end
        m_req[0] = 1'b0;
        @(negedge sys_clk);
        n_tests++;
        if ({a0.ack, a_en, a_we, a_addr, a_wdata} !== {3'b000, 5'd5, 8'hA5}) begin
            n_fail++; $display("FAIL write_idle_hold: got ack=%b en=%b we=%b addr=%0d wdata=%h want 0 0 0 5 a5", a0.ack, a_en, a_we, a_addr, a_wdata);
        end
    endtask

    task automatic test_single_read();
        @(negedge sys_clk);
        m_req[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 5'd5; m_wdata[1] = 8'h00;
        @(negedge sys_clk);
        n_tests++;
        if ({a1.ack, a0.ack, a_en, a_we, a_addr} !== {4'b1010, 5'd5}) begin
            n_fail++; $display("FAIL single_read_ack: got m1_ack=%b m0_ack=%b en=%b we=%b addr=%0d want 1 0 1 0 5", a1.ack, a0.ack, a_en, a_we, a_addr);
        end
        m_req[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge sys_clk);
            n_tests++;
            if ({a1.rvalid, b1.rvalid, a0.rvalid, b0.rvalid} !== {k == 2, k == 3, 2'b00}) begin
                n_fail++; $display("FAIL single_read_rvalid T+%0d: got a1=%b b1=%b a0=%b b0=%b want a1=%b b1=%b a0=0 b0=0",
                                   k, a1.rvalid, b1.rvalid, a0.rvalid, b0.rvalid, k == 2, k == 3);
            end
        end
        n_tests++;
        if ({a1.rdata, b1.rdata} !== 16'hA5A5) begin
            n_fail++; $display("FAIL single_read_data: got a=%h b=%h want a5 a5", a1.rdata, b1.rdata);
        end
    endtask

    task automatic test_simultaneous();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        m_req = 2'b11; m_we = 2'b11;
        m_addr[0] = 5'd3; m_wdata[0] = 8'h33; m_addr[1] = 5'd4; m_wdata[1] = 8'h44;
        @(negedge sys_clk);
        n_tests++;
        if ({a0.ack, a1.ack, a_en, a_addr} !== {3'b101, 5'd3}) begin
            n_fail++; $display("FAIL simul_first: got m0_ack=%b m1_ack=%b en=%b addr=%0d want 1 0 1 3", a0.ack, a1.ack, a_en, a_addr);
        end
        m_req[0] = 1'b0;
        @(negedge sys_clk);
        n_tests++;
        if ({a0.ack, a1.ack, a_en, a_addr} !== {3'b011, 5'd4}) begin
            n_fail++; $display("FAIL simul_second: got m0_ack=%b m1_ack=%b en=%b addr=%0d want 0 1 1 4", a0.ack, a1.ack, a_en, a_addr);
        end
        m_req[1] = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_deassert();
        m_req = 2'b11; m_we = 2'b00; m_addr[0] = 5'd1; m_addr[1] = 5'd2;
        @(negedge sys_clk);
        n_tests++;
        if ({a0.ack, a1.ack} !== 2'b10) begin
            n_fail++; $display("FAIL deassert_rr: got m0_ack=%b m1_ack=%b want 1 0", a0.ack, a1.ack);
        end
        m_req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            n_tests++;
            if ({a1.ack, a_en} !== 2'b00) begin
                n_fail++; $display("FAIL deassert_no_grant: got m1_ack=%b en=%b want 0 0", a1.ack, a_en);
            end
        end
        m_req[1] = 1'b1;
        @(negedge sys_clk);
        n_tests++;
        if (a1.ack !== 1'b1) begin
            n_fail++; $display("FAIL deassert_recover: got m1_ack=%b want 1", a1.ack);
        end
        m_req[1] = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_traffic(input string name, input int n_ops, input int n_rd, input int want_span);
        int  wait_m [2];
        int  rv_cnt, en_cnt, first_en, last_en;
        bit  done;
        op_t op;
        wait_m[0] = 0; wait_m[1] = 0;
        rv_cnt = 0; en_cnt = 0; first_en = -1; last_en = -1; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (m_req[m] && e_ack[m]) m_req[m] = 1'b0;
                if (!m_req[m]) begin
                    if (wait_m[m] > 0) wait_m[m]--;
                    else if ((m == 0 && ops0.size() > 0) || (m == 1 && ops1.size() > 0)) begin
                        if (m == 0) op = ops0.pop_front();
                        else        op = ops1.pop_front();
                        m_req[m] = 1'b1; m_we[m] = op.we; m_addr[m] = op.addr; m_wdata[m] = op.wdata;
                        wait_m[m] = op.gap;
                    end
                end
            end
            @(negedge sys_clk);
            n_tests++;
            if ({a1.ack, a0.ack, a_en, b1.ack, b0.ack, b_en} !== {e_ack, e_en, e_ack, e_en}) begin
                n_fail++; $display("FAIL %s grant c%0d: got a=%b%b/%b b=%b%b/%b want ack=%b en=%b",
                                   name, c, a1.ack, a0.ack, a_en, b1.ack, b0.ack, b_en, e_ack, e_en);
            end
            if (e_en) begin
                n_tests++;
                if ({a_we, a_addr, a_wdata} !== {e_we, e_addr, e_wdata}) begin
                    n_fail++; $display("FAIL %s ram_port c%0d: got we=%b addr=%0d wdata=%h want we=%b addr=%0d wdata=%h",
                                       name, c, a_we, a_addr, a_wdata, e_we, e_addr, e_wdata);
                end
            end
            n_tests++;
            if ({a1.rvalid, a0.rvalid, a1.rdata, a0.rdata} !== {e_rv_a, e_rd_a[1], e_rd_a[0]}) begin
                n_fail++; $display("FAIL %s read_a c%0d: got rv=%b%b d1=%h d0=%h want rv=%b d1=%h d0=%h",
                                   name, c, a1.rvalid, a0.rvalid, a1.rdata, a0.rdata, e_rv_a, e_rd_a[1], e_rd_a[0]);
            end
            n_tests++;
            if ({b1.rvalid, b0.rvalid, b1.rdata, b0.rdata} !== {e_rv_b, e_rd_b[1], e_rd_b[0]}) begin
                n_fail++; $display("FAIL %s read_b c%0d: got rv=%b%b d1=%h d0=%h want rv=%b d1=%h d0=%h",
                                   name, c, b1.rvalid, b0.rvalid, b1.rdata, b0.rdata, e_rv_b, e_rd_b[1], e_rd_b[0]);
            end
            if (a_en) begin
                en_cnt++; last_en = c;
                if (first_en < 0) first_en = c;
            end
            rv_cnt += int'(b0.rvalid) + int'(b1.rvalid);
            done = (ops0.size() == 0 && ops1.size() == 0 && m_req == 2'b00 && rv_cnt >= n_rd);
        end
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL %s timeout: got %0d read returns want %0d", name, rv_cnt, n_rd);
        end
        n_tests++;
        if (en_cnt != n_ops) begin
            n_fail++; $display("FAIL %s access_count: got %0d want %0d", name, en_cnt, n_ops);
        end
        if (want_span > 0) begin
            n_tests++;
            if (last_en - first_en + 1 != want_span) begin
                n_fail++; $display("FAIL %s span: got %0d cycles want %0d", name, last_en - first_en + 1, want_span);
            end
        end
        m_req = 2'b00;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_reset_mid_read();
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 5'd9;
        @(negedge sys_clk);
        n_tests++;
        if (a0.ack !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_ack: got %b want 1", a0.ack);
        end
        m_req[0] = 1'b0;
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a0.ack, a1.ack, a0.rvalid, a1.rvalid, a0.rdata, a1.rdata, a_en, a_we, a_addr, a_wdata,
             b0.ack, b1.ack, b0.rvalid, b1.rvalid, b0.rdata, b1.rdata, b_en, b_we, b_addr, b_wdata} !== '0) begin
            n_fail++; $display("FAIL mid_reset_async: got a en=%b addr=%0d rd0=%h b en=%b addr=%0d rd0=%h want all 0",
                               a_en, a_addr, a0.rdata, b_en, b_addr, b0.rdata);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            n_tests++;
            if ({a0.rvalid, a1.rvalid, b0.rvalid, b1.rvalid, a0.rdata, b0.rdata} !== '0) begin
                n_fail++; $display("FAIL mid_reset_no_rvalid c%0d: got rv=%b%b%b%b a_d0=%h b_d0=%h want 0",
                                   k, a0.rvalid, a1.rvalid, b0.rvalid, b1.rvalid, a0.rdata, b0.rdata);
            end
        end
    endtask

    initial begin
        int n_rd;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin m_addr[i] = '0; m_wdata[i] = '0; end
        for (int i = 0; i < 32; i++) begin
            mem_a[i] <= DW'(i * 7 + 1);
            mem_b[i] <= DW'(i * 7 + 1);
            shadow[i] = DW'(i * 7 + 1);
        end
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous();
        test_deassert();

        for (int k = 0; k < 32; k++) begin
            ops0.push_back('{we: 1'b1, addr: AW'(k), wdata: DW'(k), gap: 0});
            ops1.push_back('{we: 1'b0, addr: AW'(k), wdata: 8'h00, gap: 0});
        end
        test_traffic("dual_load", 64, 32, 64);

        for (int k = 0; k < 8; k++) begin
            ops0.push_back('{we: 1'b0, addr: AW'(k * 3 + 2), wdata: 8'h00, gap: 0});
        end
        test_traffic("stream", 8, 8, 15);

        n_rd = 0;
        for (int k = 0; k < 40; k++) begin
            ops0.push_back('{we: 1'($urandom_range(0, 1)), addr: AW'($urandom_range(0, 7)), wdata: DW'($urandom), gap: $urandom_range(0, 2)});
            ops1.push_back('{we: 1'($urandom_range(0, 1)), addr: AW'($urandom_range(0, 7)), wdata: DW'($urandom), gap: $urandom_range(0, 2)});
            if (!ops0[k].we) n_rd++;
            if (!ops1[k].we) n_rd++;
        end
        test_traffic("random", 80, n_rd, 0);

        test_reset_mid_read();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter for the single-port 32x8 block RAM. It sits between two independent masters (for example a write sequencer and a readback checker) and the RAM IP port. It serialises their read/write requests with round-robin fairness and routes read data back to the master that issued the read. All RAM-side outputs are registered.

## Interface

Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 8, RAM data width
- RD_LAT, 1, RAM read latency in cycles from the ram_en cycle to valid ram_rdata; legal values are 1 and 2

Ports:
- sys_clk  in  1  clock; all logic on the rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  one-cycle pulse; master 0 request accepted
- m0_rvalid  out  1  one-cycle pulse; m0_rdata is valid
- m0_rdata  out  DATA_W  read data for master 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: same as master 0, for master 1
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

## Operation

- **Request rules:** a master asserts req with we/addr/wdata stable and holds them until it samples ack=1. It drops req, or presents a new request, on the edge after ack.
- **Eligibility:** mX is eligible in a cycle when mX_req=1 and mX_ack=0. The ack cycle therefore never causes a double grant.
- **Arbitration:** runs each cycle over the eligible set.
  - Only one eligible master: that master wins.
  - Both eligible: the master not granted last wins.
  - last_grant resets to 1, so master 0 wins the first tie.
  - last_grant updates only on a grant.
- **Grant edge:** on the edge after a winner is chosen:
  - ram_en=1
  - ram_we, ram_addr and ram_wdata take the winner's we/addr/wdata
  - the winner's ack=1 for that one cycle
- **No winner:** ram_en=0 and ram_we=0; ram_addr and ram_wdata hold their last values.
- **Read tracking:** each grant pushes {is_read, id} into an RD_LAT-deep shift register aligned to ram_en.
  - When an is_read entry emerges (the cycle ram_rdata is valid), the next edge sets mID_rvalid=1 and mID_rdata=ram_rdata.
  - The other master's rvalid stays 0.
  - mX_rdata holds its value between reads.
- **Writes:** produce no rvalid.
- **Ordering:** RAM accesses occur in grant order. A read granted after a write to the same address returns the new data; the RAM is configured as write-first or read-after-write separated by at least one cycle.

## Timing

- **Reset values:** every output is 0 (ack, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata); last_grant=1; the read-tracking pipe is cleared.
- **Request to ack:** req sampled at edge E with the master eligible and winning → ack and ram_en high in the cycle after E (1-cycle latency).
- **Read data:** for a read granted with ram_en high in cycle T, ram_rdata is valid in T+RD_LAT and mX_rvalid is high in T+RD_LAT+1.
- **Throughput:**
  - Both masters requesting continuously: grants alternate m0, m1, m0, … and ram_en=1 every cycle.
  - A single master alone: at most one grant every 2 cycles, because of the ack-cycle exclusion.
- **Reset mid-operation:** all in-flight reads are discarded (no rvalid after reset release) and outputs return to 0 asynchronously.
- **Deassertion:** a req dropped before ack is never granted. Requesters must not do this, but the arbiter must not lock up if they do.

## Test plan

- **Single write:** m0 writes addr 5 with data 0xA5 (m0_req=1, m0_we=1) → next cycle m0_ack=1, ram_en=1, ram_we=1, ram_addr=5, ram_wdata=0xA5; m1 signals unchanged.
- **Single read:** m1 reads addr 5 after that write, RD_LAT=1 → m1_ack in cycle T, m1_rvalid=1 with m1_rdata=0xA5 in T+2, m0_rvalid=0 throughout. Repeat with RD_LAT=2 → m1_rvalid in T+3.
- **Simultaneous first request:** m0 and m1 both raise req in the first cycle after reset → m0 acked first, m1 acked the following cycle, ram_en high in both cycles.
- **Continuous dual load:** m0 writes addr 0..31 with data = addr while m1 continuously reads addr 0..31 → strict alternation, ram_en=1 every cycle, each m1 read of addr k returns k once that write has been granted.
- **Single master streaming:** m0 alone streams 8 reads → ack on every second cycle and 8 m0_rvalid pulses in order.
- **Reset mid-read:** assert sys_rst_n=0 in the cycle after a read ack → all outputs 0 immediately, and no rvalid appears after reset is released.
